fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
//  Owns the PC, issues instruction-memory reads and captures returned words.
//  Presents the IF/ID instruction, whose opcode/funct fields drive the control unit in ID.
//  Honours hazard-unit stalls, ID/EX redirects (branch/jump/jr) and the ID-stage halt.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  CLK          in   1   clock; all state updates on rising edge
//  nRST         in   1   asynchronous active-low reset
//  ihit         in   1   instruction memory returns iload this cycle
//  iload        in   32  instruction word; valid only when ihit=1
//  stall        in   1   hazard unit: hold IF/ID and PC
//  redirect     in   1   taken branch/jump/jr resolved downstream: flush and refetch
//  redirect_pc  in   32  new PC; bits [1:0] ignored, forced to 2'b00
//  halt         in   1   control-unit halt decoded from the current IF/ID instruction
//  imemREN      out  1   instruction read request
//  imemaddr     out  32  instruction address (current PC)
//  instr_o      out  32  IF/ID instruction
//  pc4_o        out  32  IF/ID PC+4 of instr_o
//  valid_o      out  1   IF/ID holds a real instruction (0 = bubble)
//  opcode_o     out  6   instr_o[31:26] as opcode_t
//  funct_o      out  6   instr_o[5:0] as funct_t
//  halted_o     out  1   fetch permanently stopped
// BEHAVIOUR
//  Reset (async, nRST=0): PC=PC_INIT, state=FETCH, instr_o=0, pc4_o=0, valid_o=0,
//   skid buffer empty, halted_o=0. imemaddr=PC_INIT and imemREN=1 while in reset.
//  imemaddr=PC always. imemREN=1 only in FETCH. opcode_o/funct_o are combinational slices.
//  States: FETCH, HOLD, HALTED. Priority per cycle: redirect > halt > stall > normal.
//  FETCH:
//   ihit & !stall -> instr_o=iload, pc4_o=PC+4, valid_o=1, PC=PC+4.
//   ihit & stall  -> iload and PC+4 go to the skid buffer, PC=PC+4, ->HOLD. IF/ID is held.
//   !ihit & !stall -> IF/ID takes a bubble (instr_o=0, valid_o=0). PC is held.
//   !ihit & stall  -> nothing changes.
//  HOLD: imemREN=0. When !stall: skid -> IF/ID with valid_o=1, ->FETCH. Otherwise hold.
//  redirect (any non-HALTED state):
//   PC={redirect_pc[31:2],2'b00}; IF/ID becomes a bubble.
//   Skid is discarded and any same-cycle ihit word is dropped. Next state FETCH.
//   Overrides stall and halt.
//  halt & !redirect:
//   IF/ID becomes a bubble and PC is frozen. Any same-cycle ihit word is dropped.
//   Next state HALTED, halted_o=1.
//  HALTED: imemREN=0 and all state frozen. Ignores ihit, stall and redirect. Only nRST exits.
//  PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000. No overflow flag.
//  Latency: the ihit cycle's word is visible on instr_o the next cycle.
//   Back-to-back ihit with no stall gives one instruction per cycle.
//  nRST asserted mid-operation: immediate return to the reset values, skid cleared.
// TESTING
//  1. Reset with PC_INIT=0; ihit=1 every cycle, iload=0x2001_0005, 0x2002_0003
//     -> imemaddr 0,4,8. instr_o follows one cycle later, pc4_o=4,8. valid_o=1.
//  2. ihit=0 for 3 cycles -> imemaddr stays 0x4 and valid_o=0.
//     Then ihit=1 -> instr captured and PC=0x8.
//  3. Stall the ihit cycle at PC=0x10 (iload=0xAC22_0000) -> HOLD, imemREN=0, IF/ID unchanged.
//     Release stall -> instr_o=0xAC22_0000, pc4_o=0x14, fetch resumes at 0x14.
//  4. redirect=1 with redirect_pc=0x0000_0103, together with ihit and stall
//     -> next imemaddr=0x100, valid_o=0, dropped word never appears on instr_o.
//  5. halt=1 -> halted_o=1, imemREN=0, PC frozen; later redirect/ihit have no effect.
//     nRST pulse -> imemaddr=PC_INIT, halted_o=0.
//  6. Start with PC=0xFFFF_FFFC via redirect; one ihit -> pc4_o=0, next imemaddr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// A one-entry skid buffer catches a word that returns while the hazard unit is stalling.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_inc;
    logic        unused_redirect_lsbs;

    assign pc_inc               = pc_q + 32'd4;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        halted_d     = halted_q;

        if (state_q != HALTED) begin
            if (redirect) begin
                // Flush: the skid word and any word arriving this cycle are wrong-path.
                pc_d         = {redirect_pc[31:2], 2'b00};
                instr_d      = '0;
                pc4_d        = '0;
                valid_d      = 1'b0;
                skid_instr_d = '0;
                skid_pc4_d   = '0;
                state_d      = FETCH;
            end else if (halt) begin
                instr_d  = '0;
                pc4_d    = '0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
                state_d  = HALTED;
            end else if (state_q == FETCH) begin
                if (ihit && !stall) begin
                    instr_d = iload;
                    pc4_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else if (ihit && stall) begin
                    skid_instr_d = iload;
                    skid_pc4_d   = pc_inc;
                    pc_d         = pc_inc;
                    state_d      = HOLD;
                end else if (!stall) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end else if (!stall) begin
                instr_d = skid_instr_q;
                pc4_d   = skid_pc4_q;
                valid_d = 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            halted_q     <= halted_d;
        end
    end

    assign imemREN  = (state_q == FETCH);
    assign imemaddr = pc_q;
    assign instr_o  = instr_q;
    assign pc4_o    = pc4_q;
    assign valid_o  = valid_q;
    assign opcode_o = instr_q[31:26];
    assign funct_o  = instr_q[5:0];
    assign halted_o = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each cycle pushes the expected IF/ID contents,
// then pops and compares them once the clock edge has produced the DUT output.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr_o;
    logic [31:0] pc4_o;
    logic        valid_o;
    logic [5:0]  opcode_o;
    logic [5:0]  funct_o;
    logic        halted_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
        logic        ren;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr_o(instr_o), .pc4_o(pc4_o),
        .valid_o(valid_o), .opcode_o(opcode_o), .funct_o(funct_o), .halted_o(halted_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        ihit = 0; iload = '0; stall = 0; redirect = 0; redirect_pc = '0; halt = 0;
        nRST = 1'b0;
        #2;
        check("rst_addr",   imemaddr, 32'h0);
        check("rst_ren",    32'(imemREN), 32'd1);
        check("rst_instr",  instr_o, 32'h0);
        check("rst_valid",  32'(valid_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Drive one cycle of inputs, push what IF/ID and the fetch port must show after the edge.
    task automatic cyc(input string tag, input bit ih, input logic [31:0] il, input bit st,
                       input bit rd, input logic [31:0] rp, input bit hl,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input bit e_valid,
                       input logic [31:0] e_addr, input bit e_ren, input bit e_halted);
        exp_t e;
        ihit = ih; iload = il; stall = st; redirect = rd; redirect_pc = rp; halt = hl;
        sb.push_back('{instr: e_instr, pc4: e_pc4, valid: e_valid,
                       addr: e_addr, ren: e_ren, halted: e_halted});
        @(posedge CLK); #1;
        e = sb.pop_front();
        check({tag, ".valid"},  32'(valid_o), 32'(e.valid));
        check({tag, ".instr"},  instr_o, e.instr);
        if (e.valid) begin
            check({tag, ".pc4"},    pc4_o, e.pc4);
            check({tag, ".opcode"}, 32'(opcode_o), 32'(e.instr[31:26]));
            check({tag, ".funct"},  32'(funct_o), 32'(e.instr[5:0]));
        end
        check({tag, ".addr"},   imemaddr, e.addr);
        check({tag, ".ren"},    32'(imemREN), 32'(e.ren));
        check({tag, ".halted"}, 32'(halted_o), 32'(e.halted));
    endtask

    initial begin
        #3;
        reset_pulse();

        // Back-to-back fetch from reset
        cyc("t1a", 1, 32'h2001_0005, 0, 0, 0, 0, 32'h2001_0005, 32'h4, 1, 32'h4, 1, 0);
        cyc("t1b", 1, 32'h2002_0003, 0, 0, 0, 0, 32'h2002_0003, 32'h8, 1, 32'h8, 1, 0);

        // Miss cycles give bubbles and hold the PC
        reset_pulse();
        cyc("t2a", 1, 32'h2001_0005, 0, 0, 0, 0, 32'h2001_0005, 32'h4, 1, 32'h4, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc("t2miss", 0, 32'hBAD0_BAD0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4, 1, 0);
        cyc("t2b", 1, 32'h2002_0003, 0, 0, 0, 0, 32'h2002_0003, 32'h8, 1, 32'h8, 1, 0);

        // Stall on the ihit cycle at 0x10 parks the word in the skid buffer
        cyc("t3a", 1, 32'h0043_2020, 0, 0, 0, 0, 32'h0043_2020, 32'hC, 1, 32'hC, 1, 0);
        cyc("t3b", 1, 32'h8C23_0004, 0, 0, 0, 0, 32'h8C23_0004, 32'h10, 1, 32'h10, 1, 0);
        cyc("t3hold", 1, 32'hAC22_0000, 1, 0, 0, 0, 32'h8C23_0004, 32'h10, 1, 32'h14, 0, 0);
        cyc("t3hold2", 1, 32'h1111_1111, 1, 0, 0, 0, 32'h8C23_0004, 32'h10, 1, 32'h14, 0, 0);
        cyc("t3rel", 0, 32'h0, 0, 0, 0, 0, 32'hAC22_0000, 32'h14, 1, 32'h14, 1, 0);
        cyc("t3c", 1, 32'h0000_000C, 0, 0, 0, 0, 32'h0000_000C, 32'h18, 1, 32'h18, 1, 0);

        // Stall with no ihit leaves everything as it was
        cyc("t3idle", 0, 32'h0, 1, 0, 0, 0, 32'h0000_000C, 32'h18, 1, 32'h18, 1, 0);

        // Redirect beats stall and a same-cycle hit
        cyc("t4rd", 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0103, 0, 32'h0, 32'h0, 0, 32'h100, 1, 0);
        cyc("t4after", 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h100, 1, 0);
        // Redirect from HOLD discards the skid word
        cyc("t4hold", 1, 32'hCAFE_F00D, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h104, 0, 0);
        cyc("t4rdh", 0, 32'h0, 1, 1, 32'h0000_0200, 0, 32'h0, 32'h0, 0, 32'h200, 1, 0);
        cyc("t4noskid", 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h200, 1, 0);
        // Redirect beats halt
        cyc("t4rdhalt", 1, 32'h5555_AAAA, 0, 1, 32'h0000_0240, 1, 32'h0, 32'h0, 0, 32'h240, 1, 0);

        // Halt freezes everything until reset
        cyc("t5halt", 1, 32'h1234_5678, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h240, 0, 1);
        cyc("t5ign", 1, 32'h8765_4321, 0, 1, 32'h0000_0300, 0, 32'h0, 32'h0, 0, 32'h240, 0, 1);
        cyc("t5ign2", 1, 32'h8765_4321, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h240, 0, 1);
        reset_pulse();

        // PC wraps modulo 2^32
        cyc("t6rd", 0, 32'h0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 1, 0);
        cyc("t6wrap", 1, 32'h0800_0040, 0, 0, 0, 0, 32'h0800_0040, 32'h0, 1, 32'h0, 1, 0);

        // Mid-operation reset after a stalled hit
        cyc("t7hold", 1, 32'h0F0F_0F0F, 1, 0, 0, 0, 32'h0800_0040, 32'h0, 1, 32'h4, 0, 0);
        reset_pulse();
        cyc("t7after", 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
